// File: rtl/obi_subordinate_mem.sv
// obi_subordinate_mem: OBI subordinate backed by a word-addressed memory,
// with a programmable grant stall and an in-order response FIFO.
module obi_subordinate_mem #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int DEPTH           = 256,
    parameter int MAX_OUTSTANDING = 2,
    parameter int GNT_DELAY       = 0
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    obi_req_i,
    output logic                    obi_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   obi_addr_i,
    input  logic                    obi_we_i,
    input  logic [DATA_WIDTH/8-1:0] obi_be_i,
    input  logic [DATA_WIDTH-1:0]   obi_wdata_i,
    output logic                    obi_rvalid_o,
    input  logic                    obi_rready_i,
    output logic [DATA_WIDTH-1:0]   obi_rdata_o,
    output logic                    obi_err_o
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int OFF = $clog2(NB);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [63:0] LIMIT = 64'(DEPTH) * 64'(NB);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((64'(1) << OFF) - 64'(1));
    localparam logic [3:0] GD = 4'(GNT_DELAY);
    localparam logic [CW-1:0] MAXC = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] LASTP = PW'(MAX_OUTSTANDING - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [MAX_OUTSTANDING];
    logic                  fifo_err [MAX_OUTSTANDING];
    logic [PW-1:0]         wptr, rptr;
    logic [CW-1:0]         count;
    logic [3:0]            stall_cnt;
    logic [IW-1:0]         idx;
    logic                  accept, pop, err;

    assign idx = obi_addr_i[OFF +: IW];
    // the range check also catches addresses that would alias onto a valid index
    assign err = (|(obi_addr_i & OFF_MASK)) | (64'(obi_addr_i) >= LIMIT);
    assign obi_gnt_o = !reset_i && obi_req_i && (stall_cnt >= GD) && (count < MAXC);
    assign accept = obi_req_i & obi_gnt_o;
    assign obi_rvalid_o = count != '0;
    assign pop = obi_rvalid_o & obi_rready_i;
    assign obi_rdata_o = obi_rvalid_o ? fifo_data[rptr] : '0;
    assign obi_err_o = obi_rvalid_o & fifo_err[rptr];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stall_cnt <= '0;
            count     <= '0;
            wptr      <= '0;
            rptr      <= '0;
        end else begin
            stall_cnt <= (!obi_req_i || accept) ? '0 : (stall_cnt < GD ? stall_cnt + 4'd1 : stall_cnt);
            count     <= count + CW'(accept) - CW'(pop);
            if (accept)
                wptr <= wptr == LASTP ? '0 : wptr + PW'(1);
            if (pop)
                rptr <= rptr == LASTP ? '0 : rptr + PW'(1);
        end
    end

    // storage arrays carry no reset; outputs are masked by rvalid instead
    always_ff @(posedge clk_i) begin
        if (accept) begin
            fifo_data[wptr] <= (!obi_we_i && !err) ? mem[idx] : '0;
            fifo_err[wptr]  <= err;
        end
        if (accept && obi_we_i && !err)
            for (int i = 0; i < NB; i++)
                if (obi_be_i[i])
                    mem[idx][8*i +: 8] <= obi_wdata_i[8*i +: 8];
    end
endmodule

// File: tb/tb_obi_subordinate_mem.sv
// tb_obi_subordinate_mem: directed and random OBI traffic; responses are
// checked by a monitor against an expected-response queue.
module tb_obi_subordinate_mem;
    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    logic req = 0, we = 0, rready = 1;
    logic [31:0] addr = 0, wdata = 0;
    logic [3:0] be = 0;
    logic gnt, rvalid, err;
    logic [31:0] rdata;

    logic req2 = 0, we2 = 0, rready2 = 1;
    logic [31:0] addr2 = 0, wdata2 = 0;
    logic [3:0] be2 = 0;
    logic gnt2, rvalid2, err2;
    logic [31:0] rdata2;

    obi_subordinate_mem dut (
        .clk_i(clk), .reset_i(rst), .obi_req_i(req), .obi_gnt_o(gnt),
        .obi_addr_i(addr), .obi_we_i(we), .obi_be_i(be), .obi_wdata_i(wdata),
        .obi_rvalid_o(rvalid), .obi_rready_i(rready), .obi_rdata_o(rdata), .obi_err_o(err)
    );

    obi_subordinate_mem #(.GNT_DELAY(3)) dut_stall (
        .clk_i(clk), .reset_i(rst), .obi_req_i(req2), .obi_gnt_o(gnt2),
        .obi_addr_i(addr2), .obi_we_i(we2), .obi_be_i(be2), .obi_wdata_i(wdata2),
        .obi_rvalid_o(rvalid2), .obi_rready_i(rready2), .obi_rdata_o(rdata2), .obi_err_o(err2)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        lat;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int checks = 0, errors = 0, cyc = 0;
    bit rand_rr = 0;
    logic [31:0] model [int];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rvalid && rready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid: got rdata %h with no response pending", rdata);
            end else begin
                mon_e = sb.pop_front();
                chk("rdata", rdata, mon_e.rdata);
                chk("err", 32'(err), 32'(mon_e.err));
                if (mon_e.lat)
                    chk("latency", cyc, mon_e.cyc + 1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
        if (rand_rr)
            rready = 1'($urandom_range(0, 1));
    endtask

    task automatic drive(input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        req = 1;
        we = w;
        addr = a;
        be = b;
        wdata = d;
    endtask

    task automatic wait_gnt(input logic [31:0] er, input logic ee, input logic lat, output int n);
        n = 0;
        #1;
        while (!gnt && n < 40) begin
            step();
            #1;
            n++;
        end
        if (!gnt) begin
            checks++;
            errors++;
            $display("FAIL gnt_timeout: gnt %0b expected 1", gnt);
        end else
            sb.push_back('{er, ee, lat, cyc});
        step();
    endtask

    task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d,
                        input logic [31:0] er, input logic ee, input logic lat);
        int n;
        drive(w, a, b, d);
        wait_gnt(er, ee, lat, n);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            step();
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses pending, expected 0", sb.size());
        end
    endtask

    initial begin
        int n;
        int a;
        logic w;
        logic [31:0] d;
        drive(1, 32'h10, 4'hF, 32'hDEADBEEF);
        repeat (2) @(posedge clk);
        #3;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_err", 32'(err), 0);
        rst = 0;
        wait_gnt(0, 0, 1, n);
        chk("rst_gnt_immediate", n, 0);

        xfer(1, 32'h10, 4'h1, 32'h000000AA, 0, 0, 1);
        xfer(0, 32'h10, 4'hF, 0, 32'hDEADBEAA, 0, 1);
        xfer(1, 32'h10, 4'h0, 32'h12345678, 0, 0, 1);
        xfer(0, 32'h10, 4'hF, 0, 32'hDEADBEAA, 0, 1);
        xfer(1, 32'h10, 4'h2, 32'h00005500, 0, 0, 1);
        xfer(0, 32'h10, 4'hF, 0, 32'hDEAD55AA, 0, 1);

        xfer(1, 32'h0, 4'hF, 32'hCAFEF00D, 0, 0, 1);
        xfer(0, 32'h12, 4'hF, 0, 0, 1, 1);
        xfer(1, 32'h400, 4'hF, 32'hFFFFFFFF, 0, 1, 1);
        xfer(1, 32'h2, 4'hF, 32'h0, 0, 1, 1);
        xfer(0, 32'h0, 4'hF, 0, 32'hCAFEF00D, 0, 1);

        xfer(1, 32'h20, 4'hF, 32'h11111111, 0, 0, 1);
        xfer(1, 32'h24, 4'hF, 32'h22222222, 0, 0, 1);
        xfer(1, 32'h28, 4'hF, 32'h33333333, 0, 0, 1);
        req = 0;
        step();

        rready = 0;
        xfer(0, 32'h20, 4'hF, 0, 32'h11111111, 0, 0);
        xfer(0, 32'h24, 4'hF, 0, 32'h22222222, 0, 0);
        drive(0, 32'h28, 4'hF, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("full_gnt", 32'(gnt), 0);
            chk("head_rvalid", 32'(rvalid), 1);
            chk("head_rdata", rdata, 32'h11111111);
            step();
        end
        rready = 1;
        #1;
        chk("gnt_during_pop", 32'(gnt), 0);
        step();
        #1;
        chk("gnt_after_pop", 32'(gnt), 1);
        sb.push_back('{32'h33333333, 1'b0, 1'b0, 0});
        step();
        req = 0;
        drain();

        rready = 0;
        xfer(0, 32'h20, 4'hF, 0, 32'h11111111, 0, 0);
        req = 0;
        #1;
        chk("pending_rvalid", 32'(rvalid), 1);
        rst = 1;
        #1;
        chk("midrst_rvalid", 32'(rvalid), 0);
        sb.delete();
        step();
        rst = 0;
        rready = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("post_rst_rvalid", 32'(rvalid), 0);
            step();
        end
        xfer(0, 32'h0, 4'hF, 0, 32'hCAFEF00D, 0, 1);
        xfer(0, 32'h10, 4'hF, 0, 32'hDEAD55AA, 0, 1);
        req = 0;
        step();

        rand_rr = 1;
        for (int k = 0; k < 100; k++) begin
            a = 32'h100 + 4 * int'($urandom_range(0, 15));
            w = 1'($urandom_range(0, 1));
            if (!model.exists(a))
                w = 1;
            d = $urandom;
            if (w) begin
                model[a] = d;
                xfer(1, 32'(a), 4'hF, d, 0, 0, 0);
            end else
                xfer(0, 32'(a), 4'hF, 0, model[a], 0, 0);
        end
        req = 0;
        rand_rr = 0;
        rready = 1;
        drain();

        req2 = 1;
        we2 = 1;
        addr2 = 32'h4;
        be2 = 4'hF;
        wdata2 = 32'h5A5A5A5A;
        for (int k = 1; k <= 4; k++) begin
            #1;
            chk("stall_gnt_wr", 32'(gnt2), 32'(k == 4));
            step();
        end
        we2 = 0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            if (k == 1) begin
                chk("stall_wr_rvalid", 32'(rvalid2), 1);
                chk("stall_wr_err", 32'(err2), 0);
            end
            chk("stall_gnt_rd", 32'(gnt2), 32'(k == 4));
            step();
        end
        req2 = 0;
        #1;
        chk("stall_rd_rvalid", 32'(rvalid2), 1);
        chk("stall_rd_rdata", rdata2, 32'h5A5A5A5A);
        step();

        chk("sb_empty", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
